// File: rtl/clk_div_bank.sv
// Bank of CH independent programmable clock dividers with glitch-free divisor updates.
// Optional tick outputs are built when CLK_DIV_BANK_TICK_EN is defined.
module clk_div_bank #(
  parameter int CH      = 4,
  parameter int W       = 31,
  parameter int DEF_DIV = 100000000
) (
  input  logic                             clk_in,
  input  logic                             reset,
  input  logic [CH-1:0]                    en,
  input  logic                             sync,
  input  logic                             div_load,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] div_sel,
  input  logic [W-1:0]                     div_val,
  output logic [CH-1:0]                    clk_out,
  output logic [CH-1:0]                    tick
);

  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic [W-1:0] val_c;

  always_comb begin
    val_c = div_val;
    if (div_val < W'(2)) val_c = W'(2);
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [SW-1:0] IDX = SW'(i);

    logic [W-1:0] cnt;
    logic [W-1:0] act;
    logic [W-1:0] pend;
    logic         pv;
    logic         co;
    logic         ld;
    logic         wrap;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] half;
    logic [W-1:0] nxt_act;

    assign ld      = div_load && (div_sel == IDX);
    assign wrap    = (cnt == act - W'(1));
    assign cnt_inc = cnt + W'(1);
    assign half    = (act >> 1) + W'(act[0]);
    assign nxt_act = pv ? pend : act;

    // act only changes while cnt==0, so cnt always stays below act
    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt  <= '0;
        act  <= W'(DEF_DIV);
        pend <= '0;
        pv   <= 1'b0;
        co   <= 1'b1;
      end else if (!en[i]) begin
        cnt <= '0;
        co  <= 1'b1;
        if (ld) begin
          act <= val_c;
          pv  <= 1'b0;
        end
      end else begin
        if (sync || wrap) begin
          cnt <= '0;
          co  <= 1'b1;
          act <= nxt_act;
          pv  <= 1'b0;
        end else begin
          cnt <= cnt_inc;
          co  <= (cnt_inc < half);
        end
        // a load on the apply edge is kept for the next period
        if (ld) begin
          pend <= val_c;
          pv   <= 1'b1;
        end
      end
    end

    assign clk_out[i] = co;

`ifdef CLK_DIV_BANK_TICK_EN
    logic tq;

    always_ff @(posedge clk_in) begin
      if (reset) tq <= 1'b0;
      else       tq <= en[i] && (sync || wrap);
    end

    assign tick[i] = tq;
`endif
  end

`ifndef CLK_DIV_BANK_TICK_EN
  assign tick = '0;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed testbench for clk_div_bank: CH=3, W=8, DEF_DIV=4.
// Expected waveforms come from hand tables and a period/phase formula.
module tb_clk_div_bank;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int DD = 4;

`ifdef CLK_DIV_BANK_TICK_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          reset;
  logic [CH-1:0] en;
  logic          sync;
  logic          div_load;
  logic [1:0]    div_sel;
  logic [W-1:0]  div_val;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  int n_chk  = 0;
  int n_pass = 0;

  clk_div_bank #(.CH(CH), .W(W), .DEF_DIV(DD)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .div_load (div_load),
    .div_sel  (div_sel),
    .div_val  (div_val),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input logic [1:0] s, input logic [W-1:0] v);
    div_load = 1'b1;
    div_sel  = s;
    div_val  = v;
    step();
    div_load = 1'b0;
  endtask

  // p==0 marks a disabled channel; k counts edges since phase 0
  task automatic run_cmp(input string tag, input int n,
                         input int p0, input int p1);
    int p [CH];
    logic [CH-1:0] ec, et;
    p[0] = p0;
    p[1] = p1;
    p[2] = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      for (int c = 0; c < CH; c++) begin
        if (p[c] == 0) begin
          ec[c] = 1'b1;
          et[c] = 1'b0;
        end else begin
          ec[c] = ((k % p[c]) < ((p[c] + 1) / 2));
          et[c] = TE && ((k % p[c]) == 0);
        end
      end
      chk({tag, "_clk"}, 32'(clk_out), 32'(ec));
      chk({tag, "_tick"}, 32'(tick), 32'(et));
    end
  endtask

  task automatic chk_sync(input string tag, input logic [CH-1:0] e);
    chk({tag, "_clk"}, 32'(clk_out), 32'h7);
    chk({tag, "_tick"}, 32'(tick), TE ? 32'(e) : 32'h0);
  endtask

  initial begin
    logic c_tab [9];
    logic t_tab [9];
    logic c28 [6];
    logic t28 [6];

    c_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    c28   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    t28   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset    = 1'b1;
    en       = '0;
    sync     = 1'b0;
    div_load = 1'b0;
    div_sel  = '0;
    div_val  = '0;
    step();
    en = 3'b011;
    step();
    chk("rst_clk", 32'(clk_out), 32'h7);
    chk("rst_tick", 32'(tick), 32'h0);

    reset = 1'b0;
    run_cmp("start", 8, 4, 4);

    // reprogram ch0 to 5 while it sits at cnt==1
    for (int i = 0; i < 9; i++) begin
      if (i == 1) load(2'd0, 8'd5);
      else step();
      chk("pend_clk0", 32'(clk_out[0]), 32'(c_tab[i]));
      chk("pend_tick0", 32'(tick[0]), TE ? 32'(t_tab[i]) : 32'h0);
    end

    load(2'd3, 8'd2);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk_sync("sync1", 3'b011);
    run_cmp("p5p4", 10, 5, 4);

    load(2'd0, 8'd4);
    load(2'd1, 8'd6);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk_sync("sync2", 3'b011);
    run_cmp("p4p6", 12, 4, 6);

    // load coinciding with sync must wait for the next wrap
    sync = 1'b1;
    load(2'd0, 8'd2);
    sync = 1'b0;
    chk_sync("sync3", 3'b011);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("syncld_clk0", 32'(clk_out[0]), 32'(c28[i]));
      chk("syncld_tick0", 32'(tick[0]), TE ? 32'(t28[i]) : 32'h0);
    end

    load(2'd0, 8'd7);
    reset = 1'b1;
    step();
    chk("midrst_clk", 32'(clk_out), 32'h7);
    chk("midrst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    run_cmp("postrst", 8, 4, 4);

    en = 3'b000;
    step();
    chk("dis_clk", 32'(clk_out), 32'h7);
    chk("dis_tick", 32'(tick), 32'h0);
    load(2'd1, 8'd0);
    chk("disld_clk", 32'(clk_out), 32'h7);
    en = 3'b011;
    run_cmp("val0", 6, 4, 2);

    en = 3'b000;
    step();
    load(2'd1, 8'd1);
    en = 3'b011;
    run_cmp("val1", 6, 4, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
